// File: rtl/mpq_cmd_sequencer.sv
// Sequencer feeding the max-priority-queue engine from a FIFO of host data bytes and commands.
// Latency: a cmd pushed into an empty FIFO with the engine idle strobes 2 cycles after its push cycle.
// Backpressure: in_ready drops while the FIFO is full; launches pace on mpq_busy. MPQ_SEQ_WATCHDOG_EN bounds the busy waits.
module mpq_cmd_sequencer #(
    parameter int FIFO_DEPTH  = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_is_cmd,
    input  logic       in_last,
    input  logic [2:0] in_cmd,
    input  logic [7:0] in_index,
    input  logic [7:0] in_value,
    input  logic       mpq_busy,
    output logic       mpq_data_valid,
    output logic [7:0] mpq_data,
    output logic       mpq_cmd_valid,
    output logic [2:0] mpq_cmd,
    output logic [7:0] mpq_index,
    output logic [7:0] mpq_value,
    output logic       seq_idle,
    output logic       seq_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_BURST   = 3'd1;
    localparam logic [2:0] ST_CMD     = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_SETTLE  = 3'd5;

    typedef struct packed {
        logic       is_cmd;
        logic       last;
        logic [2:0] cmd;
        logic [7:0] index;
        logic [7:0] value;
    } entry_t;

    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("mpq_cmd_sequencer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
    end

    entry_t        fifo_mem [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, last_cnt;
    logic [2:0]    state;
    logic          push, pop, empty, full, last_in, last_out;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr];
    assign last_in  = push && !in_is_cmd && in_last;
    assign last_out = pop && !head.is_cmd && head.last;
    assign seq_idle = empty && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {in_is_cmd, in_last, in_cmd, in_index, in_value};
    end

    // A data burst only starts once its closing byte is already buffered.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            if (state == ST_IDLE)
                pop = !mpq_busy && (head.is_cmd || (last_cnt != '0));
            else if (state == ST_BURST)
                pop = !head.is_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (last_in && !last_out)      last_cnt <= last_cnt + 1'b1;
            else if (last_out && !last_in) last_cnt <= last_cnt - 1'b1;
        end
    end

`ifdef MPQ_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    logic [WW-1:0] wd_cnt;
    logic          in_wait, wd_hit;

    assign in_wait = (state == ST_WAIT_HI) || (state == ST_WAIT_LO);
    assign wd_hit  = in_wait && (wd_cnt == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            seq_err <= 1'b0;
        end else begin
            wd_cnt <= in_wait ? wd_cnt + 1'b1 : '0;
            if (wd_hit) seq_err <= 1'b1;
        end
    end
`else
    logic wd_hit;
    assign wd_hit  = 1'b0;
    assign seq_err = 1'b0;
`endif

    // Strobes default low every cycle; the engine-side fields hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            mpq_data_valid <= 1'b0;
            mpq_data       <= '0;
            mpq_cmd_valid  <= 1'b0;
            mpq_cmd        <= '0;
            mpq_index      <= '0;
            mpq_value      <= '0;
        end else begin
            mpq_data_valid <= 1'b0;
            mpq_cmd_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head.is_cmd) begin
                            mpq_cmd_valid <= 1'b1;
                            mpq_cmd       <= head.cmd;
                            mpq_index     <= head.index;
                            mpq_value     <= head.value;
                            state         <= ST_CMD;
                        end else begin
                            mpq_data_valid <= 1'b1;
                            mpq_data       <= head.value;
                            state          <= head.last ? ST_WAIT_HI : ST_BURST;
                        end
                    end
                end
                ST_BURST: begin
                    if (pop) begin
                        mpq_data_valid <= 1'b1;
                        mpq_data       <= head.value;
                        if (head.last) state <= ST_WAIT_HI;
                    end else begin
                        state <= ST_WAIT_HI;
                    end
                end
                ST_CMD:     state <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (wd_hit)        state <= ST_SETTLE;
                    else if (mpq_busy) state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (wd_hit || !mpq_busy) state <= ST_SETTLE;
                end
                ST_SETTLE:  state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpq_cmd_sequencer.sv
// Directed bench for mpq_cmd_sequencer: cycle table plus pacing, full-FIFO, watchdog and reset sequences.
`timescale 1ns/1ps
module tb_mpq_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0, in_ready, in_is_cmd = 1'b0, in_last = 1'b0;
    logic [2:0] in_cmd = '0;
    logic [7:0] in_index = '0, in_value = '0;
    logic       mpq_busy, mpq_data_valid, mpq_cmd_valid;
    logic [7:0] mpq_data, mpq_index, mpq_value;
    logic [2:0] mpq_cmd;
    logic       seq_idle, seq_err;

    logic busy_man  = 1'b0;
    bit   auto_busy = 1'b0;
    int   stub_len  = 3;
    int   stub_cnt  = 0;
    int   n_chk = 0, n_fail = 0;

    mpq_cmd_sequencer #(.FIFO_DEPTH(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_cmd(in_is_cmd), .in_last(in_last),
        .in_cmd(in_cmd), .in_index(in_index), .in_value(in_value),
        .mpq_busy(mpq_busy), .mpq_data_valid(mpq_data_valid), .mpq_data(mpq_data),
        .mpq_cmd_valid(mpq_cmd_valid), .mpq_cmd(mpq_cmd), .mpq_index(mpq_index), .mpq_value(mpq_value),
        .seq_idle(seq_idle), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    // Engine stub: busy for stub_len cycles after the last strobe it saw.
    always @(posedge clk) begin
        if (mpq_cmd_valid && mpq_data_valid) begin
            n_fail++;
            $display("FAIL both_strobes: data_valid=1 cmd_valid=1 at %0t, required at most one", $time);
        end
        if (mpq_cmd_valid || mpq_data_valid) stub_cnt <= stub_len;
        else if (stub_cnt != 0)              stub_cnt <= stub_cnt - 1;
    end
    assign mpq_busy = auto_busy ? (stub_cnt != 0) : busy_man;

    typedef struct {
        logic       v, ic, l;
        logic [2:0] c;
        logic [7:0] ix, vl;
        logic       b;
        logic       e_cv, e_dv, e_idle;
        logic       cd;
        logic [7:0] e_data;
        logic       cc;
        logic [2:0] e_cmd;
        logic [7:0] e_idx, e_val;
    } vec_t;

    vec_t tbl [64];
    int   n_vec = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b required %0b", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic ic, input logic l, input logic [2:0] c,
                       input logic [7:0] ix, input logic [7:0] vl, input logic b,
                       input logic ecv, input logic edv, input logic eidle);
        tbl[n_vec] = '{v: v, ic: ic, l: l, c: c, ix: ix, vl: vl, b: b,
                       e_cv: ecv, e_dv: edv, e_idle: eidle,
                       cd: 1'b0, e_data: 8'h00, cc: 1'b0, e_cmd: 3'd0, e_idx: 8'h00, e_val: 8'h00};
        n_vec++;
    endtask

    task automatic exp_d(input logic [7:0] d);
        tbl[n_vec-1].cd     = 1'b1;
        tbl[n_vec-1].e_data = d;
    endtask

    task automatic exp_c(input logic [2:0] c, input logic [7:0] ix, input logic [7:0] vl);
        tbl[n_vec-1].cc    = 1'b1;
        tbl[n_vec-1].e_cmd = c;
        tbl[n_vec-1].e_idx = ix;
        tbl[n_vec-1].e_val = vl;
    endtask

    task automatic drive(input logic v, input logic ic, input logic l, input logic [2:0] c,
                         input logic [7:0] ix, input logic [7:0] vl);
        in_valid = v; in_is_cmd = ic; in_last = l; in_cmd = c; in_index = ix; in_value = vl;
    endtask

    task automatic wait_cv(input string name, input int lim);
        int c = 0;
        while (!mpq_cmd_valid && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk1(name, mpq_cmd_valid, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (!seq_idle && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk1(name, seq_idle, 1'b1);
    endtask

    initial begin
        int gap;
        int dv_seen;
        logic [7:0] k8;

        // Rows: inputs applied this cycle, expected outputs observed before they are applied.
        add(1,0,0,0,0,5,    0, 0,0,1);
        add(1,0,0,0,0,3,    0, 0,0,0);
        add(1,0,1,0,0,9,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,1,0); exp_d(5);
        add(0,0,0,0,0,0,    0, 0,1,0); exp_d(3);
        add(0,0,0,0,0,0,    0, 0,1,0); exp_d(9);
        add(0,0,0,0,0,0,    1, 0,0,0); exp_d(9);
        add(1,1,0,4,7,8'h22,1, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 1,0,0); exp_c(4,7,8'h22);
        add(0,0,0,0,0,0,    1, 0,0,0); exp_c(4,7,8'h22);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(1,1,0,1,3,9,    0, 0,0,1);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 1,0,0); exp_c(1,3,9);
        add(0,0,0,0,0,0,    1, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(1,0,0,0,0,1,    0, 0,0,1);
        add(1,1,0,2,5,6,    0, 0,0,0);
        add(1,0,1,0,0,8,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,1,0); exp_d(1);
        add(0,0,0,0,0,0,    1, 0,0,0); exp_d(1);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 1,0,0); exp_c(2,5,6);
        add(0,0,0,0,0,0,    1, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,1,0); exp_d(8);
        add(0,0,0,0,0,0,    1, 0,0,0); exp_d(8);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,0);
        add(0,0,0,0,0,0,    0, 0,0,1);

        #2 rst_n = 1'b0;
        #2;
        chk1("rst cmd_valid", mpq_cmd_valid, 1'b0);
        chk1("rst data_valid", mpq_data_valid, 1'b0);
        chk8("rst data", mpq_data, 8'h00);
        chk8("rst cmd", {5'd0, mpq_cmd}, 8'h00);
        chk8("rst index", mpq_index, 8'h00);
        chk8("rst value", mpq_value, 8'h00);
        chk1("rst in_ready", in_ready, 1'b1);
        chk1("rst seq_idle", seq_idle, 1'b1);
        chk1("rst seq_err", seq_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < n_vec; r++) begin
            @(negedge clk);
            chk1($sformatf("row%0d cmd_valid", r), mpq_cmd_valid, tbl[r].e_cv);
            chk1($sformatf("row%0d data_valid", r), mpq_data_valid, tbl[r].e_dv);
            chk1($sformatf("row%0d seq_idle", r), seq_idle, tbl[r].e_idle);
            chk1($sformatf("row%0d in_ready", r), in_ready, 1'b1);
            if (tbl[r].cd) chk8($sformatf("row%0d data", r), mpq_data, tbl[r].e_data);
            if (tbl[r].cc) begin
                chk8($sformatf("row%0d cmd", r), {5'd0, mpq_cmd}, {5'd0, tbl[r].e_cmd});
                chk8($sformatf("row%0d index", r), mpq_index, tbl[r].e_idx);
                chk8($sformatf("row%0d value", r), mpq_value, tbl[r].e_val);
            end
            drive(tbl[r].v, tbl[r].ic, tbl[r].l, tbl[r].c, tbl[r].ix, tbl[r].vl);
            busy_man = tbl[r].b;
        end
        drive(0,0,0,0,0,0);
        busy_man = 1'b0;

        // Pacing: busy held 6 cycles per strobe puts the next cmd 10 cycles after the previous.
        wait_idle("pace start idle");
        stub_len = 6;
        auto_busy = 1'b1;
        drive(1,1,0,0,8'h10,8'h20);
        @(negedge clk);
        drive(1,1,0,4,8'h11,8'h21);
        @(negedge clk);
        drive(0,0,0,0,0,0);
        chk1("pace first cmd_valid latency", mpq_cmd_valid, 1'b1);
        chk8("pace first cmd", {5'd0, mpq_cmd}, 8'd0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!mpq_cmd_valid && gap < 40);
        chk8("pace gap cycles", gap[7:0], 8'd10);
        chk8("pace second cmd", {5'd0, mpq_cmd}, 8'd4);
        chk8("pace second index", mpq_index, 8'h11);
        wait_idle("pace end idle");

        // Fill the FIFO with the engine held busy, then pop one while a push is pending.
        auto_busy = 1'b0;
        busy_man = 1'b1;
        stub_len = 3;
        for (int i = 0; i < 32; i++) begin
            drive(1,1,0,3,i[7:0],~i[7:0]);
            @(negedge clk);
        end
        drive(0,0,0,0,0,0);
        chk1("full in_ready", in_ready, 1'b0);
        chk1("full no launch", mpq_cmd_valid, 1'b0);
        drive(1,1,0,3,8'd32,~8'd32);
        busy_man = 1'b0;
        @(negedge clk);
        chk1("full pop cmd_valid", mpq_cmd_valid, 1'b1);
        chk8("full pop index", mpq_index, 8'd0);
        chk1("full after pop in_ready", in_ready, 1'b1);
        auto_busy = 1'b1;
        @(negedge clk);
        drive(0,0,0,0,0,0);
        chk1("full refill in_ready", in_ready, 1'b0);
        for (int k = 1; k <= 32; k++) begin
            k8 = k[7:0];
            wait_cv($sformatf("drain%0d cmd_valid", k), 60);
            chk8($sformatf("drain%0d index", k), mpq_index, k8);
            chk8($sformatf("drain%0d value", k), mpq_value, ~k8);
            @(negedge clk);
        end
        wait_idle("drain end idle");

`ifdef MPQ_SEQ_WATCHDOG_EN
        auto_busy = 1'b0;
        busy_man = 1'b0;
        drive(1,1,0,5,8'h33,8'h44);
        @(negedge clk);
        drive(0,0,0,0,0,0);
        wait_cv("wd cmd_valid", 10);
        for (int j = 1; j <= 16; j++) @(negedge clk);
        chk1("wd seq_err before limit", seq_err, 1'b0);
        @(negedge clk);
        chk1("wd seq_err at limit", seq_err, 1'b1);
        drive(1,1,0,2,8'h55,8'h66);
        @(negedge clk);
        drive(0,0,0,0,0,0);
        wait_cv("wd next cmd_valid", 10);
        chk8("wd next index", mpq_index, 8'h55);
        chk1("wd seq_err sticky", seq_err, 1'b1);
        wait_idle("wd end idle");
`else
        chk1("no watchdog seq_err", seq_err, 1'b0);
`endif

        // Reset during the second byte of a four-byte burst.
        auto_busy = 1'b0;
        busy_man = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1,0,(i == 4),0,0,i[7:0]);
            @(negedge clk);
        end
        drive(0,0,0,0,0,0);
        gap = 0;
        while (!(mpq_data_valid && mpq_data == 8'd2) && gap < 20) begin
            @(negedge clk);
            gap++;
        end
        chk1("rst burst reached byte2", mpq_data_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst async data_valid", mpq_data_valid, 1'b0);
        chk1("rst async seq_idle", seq_idle, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("post rst seq_idle", seq_idle, 1'b1);
        chk1("post rst in_ready", in_ready, 1'b1);
        chk1("post rst seq_err", seq_err, 1'b0);
        dv_seen = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (mpq_data_valid) dv_seen++;
        end
        chk8("post rst fifo discarded", dv_seen[7:0], 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
